// File: rtl/tlb_array_if.sv
// tlb_array_if: per-channel lookup request and registered result bundle.
interface tlb_array_if #(
  parameter int CHANNELS = 2,
  parameter int IDX_W    = 5
);
  logic [CHANNELS-1:0]       lk_valid;
  logic [32*CHANNELS-1:0]    lk_vaddr;
  logic [CHANNELS-1:0]       lk_store;
  logic [CHANNELS-1:0]       rs_valid;
  logic [32*CHANNELS-1:0]    rs_paddr;
  logic [3*CHANNELS-1:0]     rs_cattr;
  logic [CHANNELS-1:0]       rs_miss;
  logic [CHANNELS-1:0]       rs_invalid;
  logic [CHANNELS-1:0]       rs_modified;
  logic [IDX_W*CHANNELS-1:0] rs_index;

  modport master (
    output lk_valid, lk_vaddr, lk_store,
    input  rs_valid, rs_paddr, rs_cattr,
    input  rs_miss, rs_invalid, rs_modified, rs_index
  );

  modport slave (
    input  lk_valid, lk_vaddr, lk_store,
    output rs_valid, rs_paddr, rs_cattr,
    output rs_miss, rs_invalid, rs_modified, rs_index
  );
endinterface

// File: rtl/tlb_array.sv
// tlb_array: fully associative MIPS-style TLB with pipelined lookup, TLBR and TLBP.
// Define TLB_VARIABLE_PAGE_EN to store and honour per-entry PageMask.
module tlb_array #(
  parameter int ENTRIES  = 32,
  parameter int CHANNELS = 2,
  parameter int IDX_W    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       asid,
  tlb_array_if.slave       lk,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  logic [11:0]      w_mask,
  input  logic [31:0]      w_entryhi,
  input  logic [31:0]      w_entrylo0,
  input  logic [31:0]      w_entrylo1,
  input  logic [IDX_W-1:0] ridx,
  output logic [11:0]      r_mask,
  output logic [31:0]      r_entryhi,
  output logic [31:0]      r_entrylo0,
  output logic [31:0]      r_entrylo1,
  input  logic             pb_req,
  input  logic [31:0]      pb_entryhi,
  output logic             pb_miss,
  output logic [IDX_W-1:0] pb_index,
  output logic             pb_done
);

  typedef enum logic [1:0] {PB_IDLE, PB_SEARCH, PB_DONE} pb_st_e;

  logic [18:0]        vpn2_q [ENTRIES];
  logic [7:0]         asid_q [ENTRIES];
  logic [11:0]        mask_q [ENTRIES];
  logic [19:0]        pfn0_q [ENTRIES];
  logic [19:0]        pfn1_q [ENTRIES];
  logic [2:0]         c0_q   [ENTRIES];
  logic [2:0]         c1_q   [ENTRIES];
  logic [ENTRIES-1:0] d0_q, d1_q, v0_q, v1_q, g_q;

  logic [11:0]        emask [ENTRIES];
  logic [4:0]         hb    [ENTRIES];
  logic [31:0]        om    [ENTRIES];

  logic [31:0]        va    [CHANNELS];
  logic               hit   [CHANNELS];
  logic [IDX_W-1:0]   hidx  [CHANNELS];
  logic [31:0]        pa    [CHANNELS];
  logic [2:0]         ca    [CHANNELS];
  logic               hv    [CHANNELS];
  logic               hd    [CHANNELS];

  logic [CHANNELS-1:0]       rs_valid_q, rs_miss_q, rs_inv_q, rs_mod_q;
  logic [32*CHANNELS-1:0]    rs_paddr_q;
  logic [3*CHANNELS-1:0]     rs_cattr_q;
  logic [IDX_W*CHANNELS-1:0] rs_index_q;

  logic [11:0]      r_mask_q;
  logic [31:0]      r_hi_q, r_lo0_q, r_lo1_q;
  pb_st_e           pb_st_q;
  logic [18:0]      pb_vpn_q;
  logic [7:0]       pb_asid_q;
  logic             pb_hit;
  logic [IDX_W-1:0] pb_hidx;
  logic             pb_miss_q, pb_done_q;
  logic [IDX_W-1:0] pb_index_q;
  logic             unused_ok;

  function automatic logic vmatch(
    input logic [18:0] a,
    input logic [18:0] b,
    input logic [11:0] m
  );
    return ((a ^ b) & ~{7'b0, m}) == 19'b0;
  endfunction

  // Masked pages are contiguous from bit 13, so the half-select bit and
  // offset width both follow from the popcount of the mask.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
`ifdef TLB_VARIABLE_PAGE_EN
      emask[i] = mask_q[i];
`else
      emask[i] = 12'b0;
`endif
      hb[i] = 5'd12 + 5'($countones(emask[i]));
      om[i] = ~(32'hFFFF_FFFF << hb[i]);
    end
  end

  always_comb begin
    logic       sel;
    logic [19:0] pfn;
    for (int c = 0; c < CHANNELS; c++) begin
      va[c]   = lk.lk_vaddr[32*c +: 32];
      hit[c]  = 1'b0;
      hidx[c] = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (vmatch(va[c][31:13], vpn2_q[i], emask[i]) &&
            (g_q[i] || asid_q[i] == asid)) begin
          hit[c]  = 1'b1;
          hidx[c] = IDX_W'(i);
        end
      end
      sel   = va[c][hb[hidx[c]]];
      pfn   = sel ? pfn1_q[hidx[c]] : pfn0_q[hidx[c]];
      ca[c] = sel ? c1_q[hidx[c]] : c0_q[hidx[c]];
      hv[c] = sel ? v1_q[hidx[c]] : v0_q[hidx[c]];
      hd[c] = sel ? d1_q[hidx[c]] : d0_q[hidx[c]];
      pa[c] = ({pfn, 12'h000} & ~om[hidx[c]]) | (va[c] & om[hidx[c]]);
    end
  end

  always_comb begin
    pb_hit  = 1'b0;
    pb_hidx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vmatch(pb_vpn_q, vpn2_q[i], emask[i]) &&
          (g_q[i] || asid_q[i] == pb_asid_q)) begin
        pb_hit  = 1'b1;
        pb_hidx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        mask_q[i] <= '0;
        pfn0_q[i] <= '0;
        pfn1_q[i] <= '0;
        c0_q[i]   <= '0;
        c1_q[i]   <= '0;
      end
      d0_q <= '0;
      d1_q <= '0;
      v0_q <= '0;
      v1_q <= '0;
      g_q  <= '0;
    end else if (wen) begin
      vpn2_q[widx] <= w_entryhi[31:13];
      asid_q[widx] <= w_entryhi[7:0];
      mask_q[widx] <= w_mask;
      pfn0_q[widx] <= w_entrylo0[25:6];
      pfn1_q[widx] <= w_entrylo1[25:6];
      c0_q[widx]   <= w_entrylo0[5:3];
      c1_q[widx]   <= w_entrylo1[5:3];
      d0_q[widx]   <= w_entrylo0[2];
      d1_q[widx]   <= w_entrylo1[2];
      v0_q[widx]   <= w_entrylo0[1];
      v1_q[widx]   <= w_entrylo1[1];
      g_q[widx]    <= w_entrylo0[0] & w_entrylo1[0];
    end
  end

  // Payload holds when idle; flags only live alongside rs_valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs_valid_q <= '0;
      rs_miss_q  <= '0;
      rs_inv_q   <= '0;
      rs_mod_q   <= '0;
      rs_paddr_q <= '0;
      rs_cattr_q <= '0;
      rs_index_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        rs_valid_q[c] <= lk.lk_valid[c];
        rs_miss_q[c]  <= lk.lk_valid[c] & ~hit[c];
        rs_inv_q[c]   <= lk.lk_valid[c] & hit[c] & ~hv[c];
        rs_mod_q[c]   <= lk.lk_valid[c] & hit[c] & hv[c] &
                         lk.lk_store[c] & ~hd[c];
        if (lk.lk_valid[c]) begin
          rs_paddr_q[32*c +: 32]       <= pa[c];
          rs_cattr_q[3*c +: 3]         <= ca[c];
          rs_index_q[IDX_W*c +: IDX_W] <= hidx[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mask_q <= '0;
      r_hi_q   <= '0;
      r_lo0_q  <= '0;
      r_lo1_q  <= '0;
    end else begin
      r_mask_q <= emask[ridx];
      r_hi_q   <= {vpn2_q[ridx], 5'b0, asid_q[ridx]};
      r_lo0_q  <= {6'b0, pfn0_q[ridx], c0_q[ridx],
                   d0_q[ridx], v0_q[ridx], g_q[ridx]};
      r_lo1_q  <= {6'b0, pfn1_q[ridx], c1_q[ridx],
                   d1_q[ridx], v1_q[ridx], g_q[ridx]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pb_st_q    <= PB_IDLE;
      pb_vpn_q   <= '0;
      pb_asid_q  <= '0;
      pb_miss_q  <= 1'b0;
      pb_index_q <= '0;
      pb_done_q  <= 1'b0;
    end else begin
      unique case (pb_st_q)
        PB_IDLE: begin
          pb_done_q <= 1'b0;
          if (pb_req) begin
            pb_vpn_q  <= pb_entryhi[31:13];
            pb_asid_q <= pb_entryhi[7:0];
            pb_st_q   <= PB_SEARCH;
          end
        end
        PB_SEARCH: begin
          pb_miss_q  <= ~pb_hit;
          pb_index_q <= pb_hidx;
          pb_done_q  <= 1'b1;
          pb_st_q    <= PB_DONE;
        end
        PB_DONE: begin
          pb_done_q <= 1'b0;
          pb_st_q   <= PB_IDLE;
        end
        default: begin
          pb_done_q <= 1'b0;
          pb_st_q   <= PB_IDLE;
        end
      endcase
    end
  end

  assign lk.rs_valid    = rs_valid_q;
  assign lk.rs_paddr    = rs_paddr_q;
  assign lk.rs_cattr    = rs_cattr_q;
  assign lk.rs_miss     = rs_miss_q;
  assign lk.rs_invalid  = rs_inv_q;
  assign lk.rs_modified = rs_mod_q;
  assign lk.rs_index    = rs_index_q;

  assign r_mask     = r_mask_q;
  assign r_entryhi  = r_hi_q;
  assign r_entrylo0 = r_lo0_q;
  assign r_entrylo1 = r_lo1_q;
  assign pb_miss    = pb_miss_q;
  assign pb_index   = pb_index_q;
  assign pb_done    = pb_done_q;

`ifdef TLB_VARIABLE_PAGE_EN
  assign unused_ok = ^{w_entryhi[12:8], w_entrylo0[31:26],
                       w_entrylo1[31:26], pb_entryhi[12:8]};
`else
  assign unused_ok = ^{w_entryhi[12:8], w_entrylo0[31:26],
                       w_entrylo1[31:26], pb_entryhi[12:8],
                       w_mask, mask_q[0]};
`endif

endmodule

// File: tb/tb_tlb_array.sv
// tb_tlb_array: directed checks of lookup, flags, TLBR, TLBP and reset.
module tb_tlb_array;
  localparam int ENTRIES  = 32;
  localparam int CHANNELS = 2;
  localparam int IDX_W    = 5;

  logic             clk = 1'b0;
  logic             resetn;
  logic [7:0]       asid;
  logic             wen;
  logic [IDX_W-1:0] widx;
  logic [11:0]      w_mask;
  logic [31:0]      w_entryhi, w_entrylo0, w_entrylo1;
  logic [IDX_W-1:0] ridx;
  logic [11:0]      r_mask;
  logic [31:0]      r_entryhi, r_entrylo0, r_entrylo1;
  logic             pb_req;
  logic [31:0]      pb_entryhi;
  logic             pb_miss;
  logic [IDX_W-1:0] pb_index;
  logic             pb_done;

  int total = 0;
  int bad   = 0;

  tlb_array_if #(.CHANNELS(CHANNELS), .IDX_W(IDX_W)) bus ();

  tlb_array #(
    .ENTRIES(ENTRIES), .CHANNELS(CHANNELS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .resetn(resetn), .asid(asid), .lk(bus),
    .wen(wen), .widx(widx), .w_mask(w_mask),
    .w_entryhi(w_entryhi), .w_entrylo0(w_entrylo0),
    .w_entrylo1(w_entrylo1), .ridx(ridx), .r_mask(r_mask),
    .r_entryhi(r_entryhi), .r_entrylo0(r_entrylo0),
    .r_entrylo1(r_entrylo1), .pb_req(pb_req),
    .pb_entryhi(pb_entryhi), .pb_miss(pb_miss),
    .pb_index(pb_index), .pb_done(pb_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [IDX_W-1:0] i, input logic [31:0] hi,
                    input logic [31:0] lo0, input logic [31:0] lo1);
    wen = 1'b1; widx = i; w_entryhi = hi;
    w_entrylo0 = lo0; w_entrylo1 = lo1;
    step();
    wen = 1'b0;
  endtask

  task automatic req(input int c, input logic [31:0] va, input logic st);
    bus.lk_valid[c]         = 1'b1;
    bus.lk_vaddr[32*c +: 32] = va;
    bus.lk_store[c]         = st;
  endtask

  task automatic idle();
    bus.lk_valid = '0;
    bus.lk_store = '0;
  endtask

  task automatic res(input int c, input string tag, input logic [31:0] pa,
                     input logic [2:0] ca, input logic [2:0] fl,
                     input logic [IDX_W-1:0] ix);
    chk({tag, ".valid"}, bus.rs_valid[c], 1'b1);
    chk({tag, ".paddr"}, bus.rs_paddr[32*c +: 32], pa);
    chk({tag, ".cattr"}, bus.rs_cattr[3*c +: 3], ca);
    chk({tag, ".flags"}, {bus.rs_miss[c], bus.rs_invalid[c],
                          bus.rs_modified[c]}, fl);
    chk({tag, ".index"}, bus.rs_index[IDX_W*c +: IDX_W], ix);
  endtask

  task automatic flg(input int c, input string tag, input logic [2:0] fl,
                     input logic [IDX_W-1:0] ix);
    chk({tag, ".valid"}, bus.rs_valid[c], 1'b1);
    chk({tag, ".flags"}, {bus.rs_miss[c], bus.rs_invalid[c],
                          bus.rs_modified[c]}, fl);
    chk({tag, ".index"}, bus.rs_index[IDX_W*c +: IDX_W], ix);
  endtask

  initial begin
    resetn = 1'b0; asid = 8'h00; wen = 1'b0; widx = '0;
    w_mask = 12'h000; w_entryhi = '0; w_entrylo0 = '0; w_entrylo1 = '0;
    ridx = '0; pb_req = 1'b0; pb_entryhi = '0;
    bus.lk_valid = '0; bus.lk_vaddr = '0; bus.lk_store = '0;
    step();
    step();
    chk("rst.rs_valid", bus.rs_valid, 2'b00);
    chk("rst.rs_paddr", bus.rs_paddr[31:0], 32'h0);
    chk("rst.pb_done", pb_done, 1'b0);
    chk("rst.pb_miss", pb_miss, 1'b0);
    chk("rst.r_entryhi", r_entryhi, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    step();

    wr(5'd0, 32'h0000_2000, 32'h0004_445A, 32'h0);
    wr(5'd1, 32'h0000_4000, 32'h000C_CCDE, 32'h0);
    wr(5'd2, 32'h0000_6005, 32'h0000_1DD3, 32'h0000_2217);
    wr(5'd3, 32'h0000_4000, 32'h0026_665E, 32'h0);

    req(0, 32'h0000_2000, 1'b0);
    step();
    res(0, "load0", 32'h0111_1000, 3'd3, 3'b000, 5'd0);
    idle();
    step();
    chk("idle.valid", bus.rs_valid[0], 1'b0);
    chk("idle.flags", {bus.rs_miss[0], bus.rs_invalid[0],
                       bus.rs_modified[0]}, 3'b000);
    chk("idle.hold", bus.rs_paddr[31:0], 32'h0111_1000);

    req(0, 32'h0000_2000, 1'b1);
    step();
    flg(0, "store0", 3'b001, 5'd0);
    req(0, 32'h0000_4000, 1'b1);
    step();
    res(0, "store1", 32'h0333_3000, 3'd3, 3'b000, 5'd1);

    req(1, 32'hF000_0000, 1'b0);
    idle();
    req(1, 32'hF000_0000, 1'b0);
    step();
    flg(1, "miss", 3'b100, 5'd0);
    req(1, 32'h0000_3000, 1'b0);
    step();
    flg(1, "inval", 3'b010, 5'd0);
    asid = 8'h01;
    req(1, 32'h0000_2000, 1'b0);
    step();
    flg(1, "asidmiss", 3'b100, 5'd0);
    req(1, 32'h0000_7004, 1'b1);
    step();
    res(1, "global", 32'h0008_8004, 3'd2, 3'b000, 5'd2);
    asid = 8'h00;
    idle();

    req(0, 32'h0000_2000, 1'b0);
    req(1, 32'h0000_4000, 1'b1);
    step();
    res(0, "dual0", 32'h0111_1000, 3'd3, 3'b000, 5'd0);
    res(1, "dual1", 32'h0333_3000, 3'd3, 3'b000, 5'd1);
    idle();

    ridx = 5'd1;
    step();
    chk("tlbr1.hi", r_entryhi, 32'h0000_4000);
    chk("tlbr1.lo0", r_entrylo0, 32'h000C_CCDE);
    chk("tlbr1.mask", {20'h0, r_mask}, 32'h0);
    ridx = 5'd2;
    step();
    chk("tlbr2.hi", r_entryhi, 32'h0000_6005);
    chk("tlbr2.lo1", r_entrylo1, 32'h0000_2217);

    wen = 1'b1; widx = 5'd0; w_entryhi = 32'h0000_2000;
    w_entrylo0 = 32'h0015_555E; w_entrylo1 = 32'h0;
    req(0, 32'h0000_2000, 1'b0);
    step();
    wen = 1'b0;
    chk("wsame.old", bus.rs_paddr[31:0], 32'h0111_1000);
    step();
    chk("wsame.new", bus.rs_paddr[31:0], 32'h0555_5000);
    idle();

    pb_req = 1'b1; pb_entryhi = 32'h0000_4000;
    step();
    pb_req = 1'b0;
    chk("pb.early", pb_done, 1'b0);
    step();
    chk("pb.done", pb_done, 1'b1);
    chk("pb.index", pb_index, 5'd1);
    chk("pb.miss", pb_miss, 1'b0);
    step();
    chk("pb.pulse", pb_done, 1'b0);
    pb_req = 1'b1; pb_entryhi = 32'hF000_0000;
    step();
    pb_req = 1'b0;
    step();
    chk("pbm.done", pb_done, 1'b1);
    chk("pbm.miss", pb_miss, 1'b1);
    chk("pbm.index", pb_index, 5'd0);
    step();

    pb_req = 1'b1; pb_entryhi = 32'h0000_4000;
    step();
    pb_req = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("arst.valid", bus.rs_valid, 2'b00);
    #2 resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("arst.nodone", pb_done, 1'b0);
    end
    req(1, 32'h0000_4000, 1'b0);
    step();
    flg(1, "arst.miss", 3'b100, 5'd0);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tlb_array.md
TLB_ARRAY -- requirements
Module: tlb_array

Interface
REQ-001 Parameter ENTRIES, default 32, number of TLB entries; power of two, 2..64.
REQ-002 Parameter CHANNELS, default 2, number of independent lookup channels (ch0 = fetch, ch1 = data).
REQ-003 Parameter IDX_W, default $clog2(ENTRIES), entry index width.
REQ-004 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 asid  in  8  current ASID (EntryHi[7:0]), sampled with each lookup/probe.
REQ-008 lk_valid  in  CHANNELS  per-channel lookup request.
REQ-009 lk_vaddr  in  32*CHANNELS  per-channel virtual address.
REQ-010 lk_store  in  CHANNELS  per-channel access is a store.
REQ-011 rs_valid  out  CHANNELS  registered result valid, one cycle after lk_valid.
REQ-012 rs_paddr  out  32*CHANNELS  translated physical address.
REQ-013 rs_cattr  out  3*CHANNELS  cache attribute C of the selected half.
REQ-014 rs_miss / rs_invalid / rs_modified  out  CHANNELS each  refill / invalid / modified exception flags.
REQ-015 rs_index  out  IDX_W*CHANNELS  matched entry index (0 on miss).
REQ-016 wen, widx  in  1, IDX_W  TLBWI/TLBWR write strobe and target index.
REQ-017 w_mask  in  12  PageMask[24:13]; w_entryhi  in  32  VPN2[31:13], ASID[7:0]; w_entrylo0/w_entrylo1  in  32 each  PFN[25:6], C[5:3], D[2], V[1], G[0].
REQ-018 ridx  in  IDX_W; r_mask, r_entryhi, r_entrylo0, r_entrylo1  out  12/32/32/32  TLBR data, registered one cycle after ridx.
REQ-019 pb_req, pb_entryhi  in  1, 32; pb_miss, pb_index  out  1, IDX_W; pb_done  out  1  TLBP handshake.

Function
REQ-020 Entry match: (vaddr[31:13] & ~mask) == (VPN2 & ~mask) and (G or entry ASID == asid); G stored as G0 & G1 at write.
REQ-021 Half select: vaddr bit 12 for mask 0; in general the bit just above the masked field (bit 12 + popcount(mask)).
REQ-022 Multiple matching entries: lowest index wins; no error raised.
REQ-023 Lookup latency exactly 1 cycle: lk_* sampled on edge N, rs_* valid after edge N; independent per channel, fully pipelined, one request per channel per cycle.
REQ-024 rs_paddr = {PFN, offset} with page offset width 12 + popcount(mask); PFN taken from selected half, masked bits replaced by vaddr bits.
REQ-025 Flags: no match -> rs_miss=1; match, V=0 -> rs_invalid=1; match, V=1, store, D=0 -> rs_modified=1; at most one flag set.
REQ-026 rs_paddr, rs_cattr, rs_index hold last value when rs_valid=0; flags are 0 when rs_valid=0.
REQ-027 Write takes effect on the edge where wen=1; a lookup/probe/read sampled on that same edge uses pre-write contents.
REQ-028 Probe FSM IDLE -> SEARCH on pb_req; SEARCH -> DONE after one cycle; DONE pulses pb_done for 1 cycle, returns to IDLE; pb_req while not IDLE is ignored.
REQ-029 Probe compare uses pb_entryhi VPN2/ASID with the same rules as REQ-020; pb_miss=1, pb_index=0 on no match.
REQ-030 Widths: indices ≥ ENTRIES on widx/ridx are truncated to IDX_W bits.

Reset
REQ-031 resetn=0 asynchronously clears all entry V0/V1/D0/D1/G, rs_valid, pb_done, pb_miss, probe FSM to IDLE; all other outputs 0.
REQ-032 Reset mid-probe aborts it without pb_done; reset mid-lookup drops the pending result.

Configuration
REQ-033 Macro TLB_VARIABLE_PAGE_EN defined: w_mask stored and honoured per REQ-020/021/024.
REQ-034 Macro absent: w_mask ignored, r_mask reads 0, every entry is a fixed 4 KB pair (half select bit 12, offset 12 bits).

Verification
REQ-035 Entry0 entryhi 0x00002000, lo0 (0x1111<<6)|0x1A, asid 0; load 0x00002000 -> rs_paddr 0x01111000, cattr 3, no flags, rs_index 0.
REQ-036 Same entry, store 0x00002000 -> rs_modified=1; entry1 entryhi 0x00004000, lo0 (0x3333<<6)|0x1E, store 0x00004000 -> paddr 0x03333000, no flags.
REQ-037 Lookup 0xF0000000 -> rs_miss=1; lookup 0x00003000 with lo1 V=0 -> rs_invalid=1; asid=1, lookup 0x00002000 -> rs_miss=1.
REQ-038 Both channels same cycle (ch0 0x00002000 load, ch1 0x00004000 store) -> both results next cycle, correct and independent.
REQ-039 wen to index 0 and lookup of its old VPN on same edge -> old translation; following cycle -> new translation.
REQ-040 Probe 0x00004000 asid 0 -> pb_done 2 cycles later, pb_index 1, pb_miss 0; resetn pulse during SEARCH -> no pb_done, all V cleared, next lookup misses.
